// File: rtl/add_serial_32_if.sv
// ----------------------------------------------------------------------------
// add_serial_32_if
// Operand/result bundle for the digit-serial adder.
//   start       request, sampled by the adder in IDLE or DONE
//   a, b, cin   operands, captured together with start
//   busy        high while the adder is working through digits
//   done        one-cycle pulse: s / cout (and ovf) hold a fresh result
//   s, cout     registered sum and carry out of bit WIDTH-1
//   ovf         signed overflow, present only when ADD_SERIAL_OVF_EN is defined
// Modports: master = operand source / result consumer, slave = adder.
// ----------------------------------------------------------------------------
interface add_serial_32_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;
`ifdef ADD_SERIAL_OVF_EN
   logic             ovf;

   modport master (output start, a, b, cin, input busy, done, s, cout, ovf);
   modport slave  (input start, a, b, cin, output busy, done, s, cout, ovf);
`else
   modport master (output start, a, b, cin, input busy, done, s, cout);
   modport slave  (input start, a, b, cin, output busy, done, s, cout);
`endif
endinterface

// File: rtl/add_serial_32.sv
// ----------------------------------------------------------------------------
// add_serial_32
// Digit-serial adder: s = a + b + cin, DIGIT bits per clock, WIDTH/DIGIT clocks
// per result, carry kept in a register between digits.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    add_serial_32_if.slave (start/a/b/cin in; busy/done/s/cout out)
// Optional feature: define ADD_SERIAL_OVF_EN to add bus.ovf, the signed
// two's-complement overflow of the sum, registered and held alongside s.
// ----------------------------------------------------------------------------
module add_serial_32 #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   add_serial_32_if.slave bus
);
   localparam int NDIG  = WIDTH / DIGIT;
   localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

   if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
      $error("add_serial_32: WIDTH must be a positive multiple of DIGIT");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic             load;
   logic             step;
   logic             finish;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic [DIGIT:0]         dsum;
   logic [WIDTH+DIGIT-1:0] acc_cat;
   logic [WIDTH+DIGIT-1:0] a_cat;
   logic [WIDTH+DIGIT-1:0] b_cat;
   logic [WIDTH-1:0]       acc_next;
   logic [WIDTH-1:0]       a_next;
   logic [WIDTH-1:0]       b_next;
`ifdef ADD_SERIAL_OVF_EN
   logic                   msb_cin;
   logic                   ovf_next;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode and datapath control strobes.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load       = 1'b1;
               next_state = RUN;
            end else begin
               next_state = IDLE;
            end
         end
         RUN: begin
            // start is deliberately not looked at here: requests during RUN are dropped.
            step = 1'b1;
            if (cnt == LAST) begin
               finish     = 1'b1;
               next_state = DONE;
            end else begin
               next_state = RUN;
            end
         end
         DONE: begin
            if (bus.start) begin
               load       = 1'b1;
               next_state = RUN;
            end else begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // One digit of the addition plus the shifted versions of the operand/result registers.
   always_comb begin
      dsum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
      // Concatenate-and-slice shifts stay legal even when DIGIT == WIDTH.
      acc_cat  = {dsum[DIGIT-1:0], acc};
      a_cat    = {{DIGIT{1'b0}}, a_sh};
      b_cat    = {{DIGIT{1'b0}}, b_sh};
      acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];
      a_next   = a_cat[WIDTH+DIGIT-1:DIGIT];
      b_next   = b_cat[WIDTH+DIGIT-1:DIGIT];
`ifdef ADD_SERIAL_OVF_EN
      // Carry into the top bit of this digit is recovered from its sum bit.
      msb_cin  = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ dsum[DIGIT-1];
      ovf_next = msb_cin ^ dsum[DIGIT];
`endif
   end

   // Operand shift registers, carry, digit counter and partial result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= {WIDTH{1'b0}};
         b_sh  <= {WIDTH{1'b0}};
         acc   <= {WIDTH{1'b0}};
         carry <= 1'b0;
         cnt   <= {CNT_W{1'b0}};
      end else if (load) begin
         a_sh  <= bus.a;
         b_sh  <= bus.b;
         acc   <= {WIDTH{1'b0}};
         carry <= bus.cin;
         cnt   <= {CNT_W{1'b0}};
      end else if (step) begin
         a_sh  <= a_next;
         b_sh  <= b_next;
         acc   <= acc_next;
         carry <= dsum[DIGIT];
         cnt   <= cnt + CNT_W'(1);
      end else begin
         cnt   <= cnt;
      end
   end

   // Registered outputs; s/cout/ovf change only on the edge that enters DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.s    <= {WIDTH{1'b0}};
         bus.cout <= 1'b0;
`ifdef ADD_SERIAL_OVF_EN
         bus.ovf  <= 1'b0;
`endif
      end else begin
         bus.busy <= (next_state == RUN);
         bus.done <= (next_state == DONE);
         if (finish) begin
            bus.s    <= acc_next;
            bus.cout <= dsum[DIGIT];
`ifdef ADD_SERIAL_OVF_EN
            bus.ovf  <= ovf_next;
`endif
         end else begin
            bus.cout <= bus.cout;
         end
      end
   end
endmodule
